io_bridge: RTL and testbench



---
 rtl/io_bridge_pkg.sv | 69 ++++++
 rtl/io_bridge_if.sv | 25 ++
 rtl/io_bridge_seg_scan.sv | 51 +++++
 rtl/io_bridge.sv | 116 +++++++++++
 tb/tb_io_bridge.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU data-port bridge: peripheral address map,
// target decode and the 7-segment hex font.
package io_bridge_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned OFF_W = 12;
    localparam int unsigned SW_W  = 24;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned LED_W = 24;

    localparam logic [BUS_W-1:0] PERIPH_BASE = 32'hFFFF_F000;

    localparam logic [OFF_W-1:0] OFF_SEG  = 12'h000;
    localparam logic [OFF_W-1:0] OFF_TCNT = 12'h020;
    localparam logic [OFF_W-1:0] OFF_TCTL = 12'h024;
    localparam logic [OFF_W-1:0] OFF_LED  = 12'h060;
    localparam logic [OFF_W-1:0] OFF_SW   = 12'h070;
    localparam logic [OFF_W-1:0] OFF_BTN  = 12'h078;

    typedef enum logic [2:0] {
        TGT_DRAM,
        TGT_SEG,
        TGT_TCNT,
        TGT_TCTL,
        TGT_LED,
        TGT_SW,
        TGT_BTN,
        TGT_NONE
    } target_e;

    // Takes the word address (byte address bits [31:2]); byte lanes never matter.
    function automatic target_e decode_target(input logic [BUS_W-3:0] word_addr);
        if (word_addr[BUS_W-3:OFF_W-2] != PERIPH_BASE[BUS_W-1:OFF_W]) begin
            return TGT_DRAM;
        end
        case ({word_addr[OFF_W-3:0], 2'b00})
            OFF_SEG:  return TGT_SEG;
            OFF_TCNT: return TGT_TCNT;
            OFF_TCTL: return TGT_TCTL;
            OFF_LED:  return TGT_LED;
            OFF_SW:   return TGT_SW;
            OFF_BTN:  return TGT_BTN;
            default:  return TGT_NONE;
        endcase
    endfunction

    // Active-low segments {G,F,E,D,C,B,A} for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-port bus plus the DRAM side of the bridge.
interface io_bridge_if #(
    parameter int unsigned DRAM_AW = 14
);
    logic [31:0]        Bus_addr;
    logic               Bus_wen;
    logic [31:0]        Bus_wdata;
    logic [31:0]        Bus_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_wen;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;

    // CPU core and DRAM macro side
    modport master (
        output Bus_addr, Bus_wen, Bus_wdata, dram_rdata,
        input  Bus_rdata, dram_addr, dram_wen, dram_wdata
    );

    // Bridge side
    modport slave (
        input  Bus_addr, Bus_wen, Bus_wdata, dram_rdata,
        output Bus_rdata, dram_addr, dram_wen, dram_wdata
    );
endinterface

// File: rtl/io_bridge_seg_scan.sv
// Time-multiplexed 8-digit 7-segment driver; the digit and its pattern are
// captured together at the start of each slot so a slot never tears.
module seg_scan
    import io_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] value,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             slot_start;
    logic             slot_end;

    always_comb begin
        slot_start = (div_cnt == '0);
        slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    end

    // Slot timer and digit index
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Outputs load once per slot; blank until the first slot starts
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_en <= 8'hFF;
            seg    <= 8'hFF;
        end else if (slot_start) begin
            dig_en <= ~(8'h01 << idx);
            seg    <= {1'b1, hex_to_seg(value[{idx, 2'b00} +: 4])};
        end
    end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge on the CPU data port: steers each access to DRAM or to
// the LED, switch/button, timer and 7-segment registers.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned DRAM_AW   = 14,
    parameter int unsigned SCAN_DIV  = 20000,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    io_bridge_if.slave       bus,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn,
    output logic [LED_W-1:0] led,
    output logic [7:0]       dig_en,
    output logic [7:0]       seg
);

    localparam int unsigned PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    target_e          tgt;
    logic             wr_seg, wr_tcnt, wr_tctl, wr_led;
    logic             tick;
    logic             unused_addr_bits;

    logic [BUS_W-1:0] seg_val;
    logic [BUS_W-1:0] tcnt;
    logic             run;
    logic [PRE_W-1:0] presc;
    logic [SW_W-1:0]  sw_meta, sw_sync;
    logic [BTN_W-1:0] btn_meta, btn_sync;

    // Address decode and DRAM pass-through
    always_comb begin
        tgt              = decode_target(bus.Bus_addr[BUS_W-1:2]);
        unused_addr_bits = ^bus.Bus_addr[1:0];
        bus.dram_addr    = bus.Bus_addr[DRAM_AW+1:2];
        bus.dram_wdata   = bus.Bus_wdata;
        bus.dram_wen     = bus.Bus_wen && (tgt == TGT_DRAM) && cpu_rst;
        wr_seg           = bus.Bus_wen && (tgt == TGT_SEG);
        wr_tcnt          = bus.Bus_wen && (tgt == TGT_TCNT);
        wr_tctl          = bus.Bus_wen && (tgt == TGT_TCTL);
        wr_led           = bus.Bus_wen && (tgt == TGT_LED);
        tick             = run && (presc == PRE_W'(TIMER_DIV - 1));
    end

    // Same-cycle read mux
    always_comb begin
        bus.Bus_rdata = '0;
        case (tgt)
            TGT_DRAM: bus.Bus_rdata = bus.dram_rdata;
            TGT_SEG:  bus.Bus_rdata = seg_val;
            TGT_TCNT: bus.Bus_rdata = tcnt;
            TGT_TCTL: bus.Bus_rdata = {31'h0, run};
            TGT_LED:  bus.Bus_rdata = {8'h0, led};
            TGT_SW:   bus.Bus_rdata = {8'h0, sw_sync};
            TGT_BTN:  bus.Bus_rdata = {27'h0, btn_sync};
            default:  bus.Bus_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            led     <= '0;
            seg_val <= '0;
            run     <= 1'b0;
        end else begin
            if (wr_led) led <= bus.Bus_wdata[LED_W-1:0];
            if (wr_seg) seg_val <= bus.Bus_wdata;
            if (wr_tctl) run <= bus.Bus_wdata[0];
        end
    end

    // Timer: a CPU write to TCNT overrides a coincident increment
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            tcnt  <= '0;
            presc <= '0;
        end else if (wr_tcnt) begin
            tcnt  <= bus.Bus_wdata;
            presc <= '0;
        end else if (tick) begin
            tcnt  <= tcnt + 32'd1;
            presc <= '0;
        end else if (run) begin
            presc <= presc + PRE_W'(1);
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .value   (seg_val),
        .dig_en  (dig_en),
        .seg     (seg)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: directed vector table, hand-written timer/display/reset
// sequences and a randomized run against a behavioural model.
module tb_io_bridge;

    localparam int unsigned DAW = 14;
    localparam int unsigned SD  = 2;
    localparam int unsigned TD  = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    io_bridge_if #(.DRAM_AW(DAW)) bus ();

    io_bridge #(
        .DRAM_AW   (DAW),
        .SCAN_DIV  (SD),
        .TIMER_DIV (TD)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus.slave),
        .sw      (sw),
        .btn     (btn),
        .led     (led),
        .dig_en  (dig_en),
        .seg     (seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    // DRAM contents; written only by the reference model
    logic [31:0] mem [0:(1<<DAW)-1];
    assign bus.dram_rdata = mem[bus.dram_addr];

    // Reference model state
    logic [23:0] m_led;
    logic [31:0] m_seg;
    logic [31:0] m_tcnt;
    logic        m_run;
    int          m_ticks;
    int          m_k;
    logic [7:0]  m_dig;
    logic [7:0]  m_segout;
    logic [28:0] m_s1, m_s2;
    logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [23:0] swv;
        logic [31:0] exp_rdata;
        logic        exp_dwen;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic is_periph(input logic [31:0] a);
        return a[31:12] == 20'hFFFFF;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (!is_periph(a)) return mem[a[DAW+1:2]];
        case ({a[11:2], 2'b00})
            12'h000: return m_seg;
            12'h020: return m_tcnt;
            12'h024: return {31'h0, m_run};
            12'h060: return {8'h0, m_led};
            12'h070: return {8'h0, m_s2[28:5]};
            12'h078: return {27'h0, m_s2[4:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = '0; m_seg = '0; m_tcnt = '0; m_run = 1'b0;
        m_ticks = 0; m_k = 0; m_dig = 8'hFF; m_segout = 8'hFF;
        m_s1 = '0; m_s2 = '0;
    endtask

    // State change at one rising edge, given the bus inputs applied before it
    task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic        p;
        logic [11:0] off;
        int          idx;
        p   = is_periph(a);
        off = {a[11:2], 2'b00};
        if (m_k % SD == 0) begin
            idx      = (m_k / SD) % 8;
            m_dig    = ~(8'h01 << idx);
            m_segout = {1'b1, font[m_seg[4*idx +: 4]]};
        end
        m_k++;
        if (w && p && off == 12'h020) begin
            m_tcnt  = d;
            m_ticks = 0;
        end else if (m_run) begin
            m_ticks++;
            if (m_ticks == TD) begin
                m_ticks = 0;
                m_tcnt  = m_tcnt + 32'd1;
            end
        end
        if (w && p) begin
            case (off)
                12'h000: m_seg = d;
                12'h024: m_run = d[0];
                12'h060: m_led = d[23:0];
                default: ;
            endcase
        end
        if (w && !p) mem[a[DAW+1:2]] = d;
        m_s2 = m_s1;
        m_s1 = {sw, btn};
    endtask

    // One bus cycle: drive, check combinational and registered outputs, clock
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic use_c = 1'b0, input logic [31:0] c_rdata = 32'h0,
                        input logic c_dwen = 1'b0);
        bus.Bus_addr  = a;
        bus.Bus_wen   = w;
        bus.Bus_wdata = d;
        #1;
        check("rdata", bus.Bus_rdata, model_rdata(a));
        check("dram_wen", 32'(bus.dram_wen), 32'(w && !is_periph(a)));
        check("dram_addr", 32'(bus.dram_addr), 32'(a[DAW+1:2]));
        check("dram_wdata", bus.dram_wdata, d);
        check("led", 32'(led), 32'(m_led));
        check("dig_en", 32'(dig_en), 32'(m_dig));
        check("seg", 32'(seg), 32'(m_segout));
        if (use_c) begin
            check("vec_rdata", bus.Bus_rdata, c_rdata);
            check("vec_dram_wen", 32'(bus.dram_wen), 32'(c_dwen));
        end
        @(posedge cpu_clk);
        model_edge(a, w, d);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [11:0] unm [6] = '{12'h004, 12'h028, 12'h064, 12'h07C, 12'h100, 12'hFFC};
        int          sel;

        for (int i = 0; i < (1 << DAW); i++) mem[i] = 32'h0;
        cpu_rst = 1'b0;
        sw = '0; btn = '0;
        bus.Bus_addr = 32'h0000_0040; bus.Bus_wen = 1'b1; bus.Bus_wdata = 32'hCAFE_F00D;
        model_reset();
        #12;
        check("reset_led", 32'(led), 32'h0);
        check("reset_dig_en", 32'(dig_en), 32'hFF);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_dram_wen", 32'(bus.dram_wen), 32'h0);
        check("reset_dram_addr", 32'(bus.dram_addr), 32'h10);
        cpu_rst = 1'b1;
        bus.Bus_wen = 1'b0;

        // Directed vectors
        vecs.push_back(vec_t'{32'h0000_0010, 1'b1, 32'h1234_5678, 24'h0,    32'h0,         1'b1});
        vecs.push_back(vec_t'{32'h0000_0010, 1'b0, 32'h0,         24'h0,    32'h1234_5678, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F060, 1'b1, 32'hFFA5_5A5A, 24'h0,    32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F060, 1'b0, 32'h0,         24'h0,    32'h00A5_5A5A, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F063, 1'b0, 32'h0,         24'h0,    32'h00A5_5A5A, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F000, 1'b1, 32'h0123_4567, 24'h0,    32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F000, 1'b0, 32'h0,         24'h0,    32'h0123_4567, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F100, 1'b0, 32'h0,         24'h0,    32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F100, 1'b1, 32'hDEAD_BEEF, 24'h0,    32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F100, 1'b0, 32'h0,         24'h0,    32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F070, 1'b0, 32'h0,         24'hC0DE, 32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F070, 1'b0, 32'h0,         24'hC0DE, 32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F070, 1'b0, 32'h0,         24'hC0DE, 32'h0000_C0DE, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF, 24'hC0DE, 32'h0000_C0DE, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F070, 1'b0, 32'h0,         24'hC0DE, 32'h0000_C0DE, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F020, 1'b1, 32'h0000_0007, 24'hC0DE, 32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F020, 1'b0, 32'h0,         24'hC0DE, 32'h0000_0007, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F024, 1'b0, 32'h0,         24'hC0DE, 32'h0,         1'b0});
        vecs.push_back(vec_t'{32'hFFFE_F060, 1'b1, 32'h0000_AAAA, 24'hC0DE, 32'h0,         1'b1});
        vecs.push_back(vec_t'{32'h0000_F060, 1'b0, 32'h0,         24'hC0DE, 32'h0000_AAAA, 1'b0});
        vecs.push_back(vec_t'{32'hFFFF_F060, 1'b0, 32'h0,         24'hC0DE, 32'h00A5_5A5A, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            sw = vecs[i].swv;
            step(vecs[i].addr, vecs[i].wen, vecs[i].wdata, 1'b1, vecs[i].exp_rdata, vecs[i].exp_dwen);
        end

        // Reset asserted between edges while the timer runs and LEDs are lit
        step(32'hFFFF_F024, 1'b1, 32'h1);
        step(32'hFFFF_F060, 1'b1, 32'h00AB_CDEF);
        step(32'hFFFF_F000, 1'b0, 32'h0);
        bus.Bus_addr = 32'h0000_0010; bus.Bus_wen = 1'b1; bus.Bus_wdata = 32'h5555_AAAA;
        #2;
        cpu_rst = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_dig_en", 32'(dig_en), 32'hFF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        check("async_rst_dram_wen", 32'(bus.dram_wen), 32'h0);
        check("async_rst_rdata", bus.Bus_rdata, 32'h1234_5678);
        model_reset();
        @(posedge cpu_clk);
        #5;
        cpu_rst = 1'b1;
        bus.Bus_wen = 1'b0;

        // Display walk from reset release; digit 0 shows the new SEG on the next lap
        step(32'hFFFF_F000, 1'b1, 32'h0123_4567);
        check("walk_dig_en_0", 32'(dig_en), 32'hFE);
        for (int j = 1; j <= 16; j++) begin
            step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
            check("walk_dig_en", 32'(dig_en), 32'(8'(~(8'h01 << ((j / 2) % 8)))));
        end
        check("digit0_seg", 32'(seg), 32'hF8);

        // Timer
        step(32'hFFFF_F024, 1'b1, 32'h1);
        repeat (40) step(32'hFFFF_F020, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'd10, 1'b0);
        step(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFF);
        repeat (3) step(32'hFFFF_F020, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        step(32'hFFFF_F020, 1'b1, 32'h0000_0100);
        repeat (3) step(32'hFFFF_F020, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b1, 32'h0000_0055);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0);
        repeat (2) step(32'hFFFF_F020, 1'b0, 32'h0);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0);
        step(32'hFFFF_F020, 1'b0, 32'h0, 1'b1, 32'h56, 1'b0);
        step(32'hFFFF_F078, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                sw  = 24'($urandom);
                btn = 5'($urandom);
            end
            sel = int'($urandom_range(0, 9));
            d   = $urandom;
            case (sel)
                0, 1:    a = 32'($urandom_range(0, 1023));
                2:       a = $urandom & 32'hFFFF_EFFF;
                3:       a = 32'hFFFF_F000;
                4: begin
                    a = 32'hFFFF_F020;
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
                5: begin
                    a = 32'hFFFF_F024;
                    d = {31'($urandom), ($urandom_range(0, 3) != 0)};
                end
                6:       a = 32'hFFFF_F060;
                7:       a = 32'hFFFF_F070;
                8:       a = 32'hFFFF_F078;
                default: a = 32'hFFFF_F000 | 32'(unm[$urandom_range(0, 5)]);
            endcase
            a = a | 32'($urandom_range(0, 3));
            step(a, ($urandom_range(0, 2) == 0), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
